// File: rtl/melody_sequencer.sv
// melody_sequencer
// Walks a note ROM of {beats[7:5], tone[4:0]} entries and drives the buzzer
// tone/enable for beats*BEAT_CYCLES clocks per entry, followed by a silent gap.
// Handles rests (tone 0 or above 21), an end-of-song marker (beats 0),
// looping back to entry 0, and abort on stop. All outputs are registered and
// change on the same edge as the state they belong to.
module melody_sequencer #(
    parameter int BEAT_CYCLES = 3_000_000,
    parameter int GAP_CYCLES  = 120_000,
    parameter int SONG_LEN    = 32,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [4:0]        tone,
    output logic              buzzer_en,
    output logic              busy,
    output logic              done
);

    // Counter widths; a 1-bit floor keeps degenerate parameters legal.
    localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t            state_r;
    logic [BEAT_W-1:0] beat_cnt_r;
    logic [2:0]        beats_left_r;
    logic [GAP_W-1:0]  gap_cnt_r;

    logic [2:0] rom_beats_s;
    logic [4:0] rom_tone_s;
    logic       rom_is_note_s;
    logic       play_last_s;
    logic       note_end_s;
    logic       song_end_s;

    // Decode the ROM entry and work out whether this cycle finishes a note or the song.
    always_comb begin
        rom_beats_s   = rom_data[7:5];
        rom_tone_s    = rom_data[4:0];
        rom_is_note_s = (rom_tone_s != 5'd0) && (rom_tone_s <= 5'd21);
        play_last_s   = (state_r == S_PLAY) && (beat_cnt_r == BEAT_LAST) &&
                        (beats_left_r == 3'd1);
        if (GAP_CYCLES == 0) begin
            // Without a gap the note hands straight over to the next fetch.
            note_end_s = play_last_s;
        end else begin
            note_end_s = (state_r == S_GAP) && (gap_cnt_r == GAP_LAST);
        end
        song_end_s = ((state_r == S_LOAD) && (rom_beats_s == 3'd0)) ||
                     (note_end_s && (rom_addr == ADDR_LAST));
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst || stop) begin
            // Reset and abort share one quiet state; abort never pulses done.
            state_r      <= S_IDLE;
            rom_addr     <= {ADDR_W{1'b0}};
            tone         <= 5'd0;
            buzzer_en    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            beat_cnt_r   <= {BEAT_W{1'b0}};
            beats_left_r <= 3'd0;
            gap_cnt_r    <= {GAP_W{1'b0}};
        end else begin
            done <= 1'b0;
            if (song_end_s) begin
                tone       <= 5'd0;
                buzzer_en  <= 1'b0;
                rom_addr   <= {ADDR_W{1'b0}};
                beat_cnt_r <= {BEAT_W{1'b0}};
                gap_cnt_r  <= {GAP_W{1'b0}};
                if (loop) begin
                    state_r <= S_FETCH;
                end else begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
            end else if (note_end_s) begin
                state_r    <= S_FETCH;
                rom_addr   <= rom_addr + ADDR_W'(1);
                tone       <= 5'd0;
                buzzer_en  <= 1'b0;
                beat_cnt_r <= {BEAT_W{1'b0}};
                gap_cnt_r  <= {GAP_W{1'b0}};
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (start) begin
                            state_r  <= S_FETCH;
                            rom_addr <= {ADDR_W{1'b0}};
                            busy     <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        state_r <= S_LOAD;
                    end
                    S_LOAD: begin
                        // Marker entries never reach here; song_end_s handles them.
                        state_r      <= S_PLAY;
                        beats_left_r <= rom_beats_s;
                        beat_cnt_r   <= {BEAT_W{1'b0}};
                        tone         <= rom_is_note_s ? rom_tone_s : 5'd0;
                        buzzer_en    <= rom_is_note_s;
                    end
                    S_PLAY: begin
                        if (beat_cnt_r == BEAT_LAST) begin
                            beat_cnt_r <= {BEAT_W{1'b0}};
                            if (beats_left_r == 3'd1) begin
                                state_r   <= S_GAP;
                                gap_cnt_r <= {GAP_W{1'b0}};
                                tone      <= 5'd0;
                                buzzer_en <= 1'b0;
                            end else begin
                                beats_left_r <= beats_left_r - 3'd1;
                            end
                        end else begin
                            beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
                        end
                    end
                    S_GAP: begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                    default: begin
                        state_r   <= S_IDLE;
                        rom_addr  <= {ADDR_W{1'b0}};
                        tone      <= 5'd0;
                        buzzer_en <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
